// File: rtl/multi_debouncer.sv
// N-channel switch debouncer: 2-flop synchroniser, stability counter, debounced state and registered up/down pulses.
// Optional long-press detector is built when LONG_PRESS_EN is defined; otherwise long_press is constant 0.
module multi_debouncer #(
  parameter int                  CHANNELS        = 4,
  parameter int                  DEBOUNCE_CYCLES = 131072,
  parameter int                  CNT_W           = $clog2(DEBOUNCE_CYCLES),
  parameter logic [CHANNELS-1:0] INIT_STATE      = {CHANNELS{1'b0}},
  parameter int                  LONG_CYCLES     = 8388608
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [CHANNELS-1:0] switch_input,
  input  logic [CHANNELS-1:0] ch_enable,
  output logic [CHANNELS-1:0] state,
  output logic [CHANNELS-1:0] trans_up,
  output logic [CHANNELS-1:0] trans_dn,
  output logic                any_event,
  output logic [CHANNELS-1:0] long_press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0] sync_0;
  logic [CHANNELS-1:0] sync_1;
  logic [CHANNELS-1:0] toggle;
  logic [CNT_W-1:0]    cnt [CHANNELS];

  always_comb begin
    toggle = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      toggle[i] = ch_enable[i] && (sync_1[i] != state[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // Synchroniser, stability counters, state and transition pulses
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_0    <= INIT_STATE;
      sync_1    <= INIT_STATE;
      state     <= INIT_STATE;
      trans_up  <= '0;
      trans_dn  <= '0;
      any_event <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync_0    <= switch_input;
      sync_1    <= sync_0;
      state     <= state ^ toggle;
      trans_up  <= toggle & ~state;
      trans_dn  <= toggle & state;
      any_event <= |toggle;
      for (int i = 0; i < CHANNELS; i++) begin
        if (!ch_enable[i] || (sync_1[i] == state[i]) || (cnt[i] == CNT_LAST)) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef LONG_PRESS_EN
  localparam int                HOLD_W    = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0]   hold [CHANNELS];
  logic [CHANNELS-1:0] fired;

  // Hold counters: saturate at HOLD_LAST, fire once per press, re-arm when released or disabled
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fired      <= '0;
      long_press <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        long_press[i] <= 1'b0;
        if (!state[i] || !ch_enable[i]) begin
          hold[i]  <= '0;
          fired[i] <= 1'b0;
        end else if (hold[i] != HOLD_LAST) begin
          hold[i] <= hold[i] + 1'b1;
        end else if (!fired[i]) begin
          long_press[i] <= 1'b1;
          fired[i]      <= 1'b1;
        end
      end
    end
  end
`else
  // No detector in this build: the expression is constant 0 for any legal LONG_CYCLES
  assign long_press = {CHANNELS{LONG_CYCLES < 0}};
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// Randomised and directed bench for multi_debouncer, checked against a cycle-level behavioural model.
module tb_multi_debouncer;
  localparam int         CH   = 4;
  localparam int         DC   = 4;
  localparam int         LC   = 8;
  localparam logic [3:0] INIT = 4'b0100;
`ifdef LONG_PRESS_EN
  localparam bit LP_ON = 1'b1;
`else
  localparam bit LP_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] switch_input = INIT;
  logic [3:0] ch_enable = 4'hF;
  logic [3:0] state, trans_up, trans_dn, long_press;
  logic       any_event;

  int vectors = 0;
  int errors  = 0;

  multi_debouncer #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(DC), .INIT_STATE(INIT), .LONG_CYCLES(LC)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .switch_input(switch_input), .ch_enable(ch_enable),
    .state(state), .trans_up(trans_up), .trans_dn(trans_dn),
    .any_event(any_event), .long_press(long_press)
  );

  always #5 CLK = ~CLK;

  // Reference: input delayed two samples, run length of enabled mismatch cycles, held-high cycle count
  logic [3:0] m_s0, m_s1, m_state, m_up, m_dn, m_lp, m_flip, m_lp_next;
  logic       m_any;
  int         m_run  [4];
  int         m_hold [4];

  always_comb begin
    m_flip    = '0;
    m_lp_next = '0;
    for (int i = 0; i < 4; i++) begin
      m_flip[i]    = ch_enable[i] && (m_s1[i] != m_state[i]) && (m_run[i] == DC - 1);
      m_lp_next[i] = LP_ON && m_state[i] && ch_enable[i] && (m_hold[i] == LC - 1);
    end
  end

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_s0 <= INIT; m_s1 <= INIT; m_state <= INIT;
      m_up <= '0; m_dn <= '0; m_any <= 1'b0; m_lp <= '0;
      for (int i = 0; i < 4; i++) begin
        m_run[i]  <= 0;
        m_hold[i] <= 0;
      end
    end else begin
      m_s0    <= switch_input;
      m_s1    <= m_s0;
      m_state <= m_state ^ m_flip;
      m_up    <= m_flip & ~m_state;
      m_dn    <= m_flip & m_state;
      m_any   <= |m_flip;
      m_lp    <= m_lp_next;
      for (int i = 0; i < 4; i++) begin
        if (ch_enable[i] && (m_s1[i] != m_state[i])) m_run[i] <= (m_run[i] == DC - 1) ? 0 : m_run[i] + 1;
        else                                          m_run[i] <= 0;
        m_hold[i] <= (m_state[i] && ch_enable[i]) ? m_hold[i] + 1 : 0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    vectors++;
    if ({state, trans_up, trans_dn, any_event, long_press} !== {INIT, 4'b0, 4'b0, 1'b0, 4'b0}) begin
      errors++;
      $display("FAIL reset_state got st=%b up=%b dn=%b any=%b lp=%b exp st=%b rest 0",
               state, trans_up, trans_dn, any_event, long_press, INIT);
    end
    RST_N = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      vectors++;
      if ({state, trans_up, trans_dn, any_event} !== {INIT, 4'b0, 4'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_release t=%0d got st=%b up=%b dn=%b any=%b", k, state, trans_up, trans_dn, any_event);
      end
    end
  endtask

  task automatic test_clean_edge();
    switch_input[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      vectors++;
      if ({state, trans_up, trans_dn, any_event} !==
          {3'b010, (k >= 6), (k == 6) ? 4'b0001 : 4'b0000, 4'b0000, (k == 6)}) begin
        errors++;
        $display("FAIL clean_edge t=%0d got st=%b up=%b dn=%b any=%b", k, state, trans_up, trans_dn, any_event);
      end
    end
    switch_input[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      vectors++;
      if ({state, trans_up, trans_dn, any_event, long_press} !== {m_state, m_up, m_dn, m_any, m_lp}) begin
        errors++;
        $display("FAIL clean_release t=%0d got %b/%b/%b/%b/%b exp %b/%b/%b/%b/%b", k, state, trans_up,
                 trans_dn, any_event, long_press, m_state, m_up, m_dn, m_any, m_lp);
      end
    end
  endtask

  task automatic test_bounce();
    int ups = 0;
    int dns = 0;
    for (int k = 1; k <= 16; k++) begin
      switch_input[0] = (k == 4) ? 1'b0 : 1'b1;
      tick();
      ups += trans_up[0];
      vectors++;
      if (trans_up[0] !== (k == 10) ||
          {state, trans_up, trans_dn, any_event, long_press} !== {m_state, m_up, m_dn, m_any, m_lp}) begin
        errors++;
        $display("FAIL bounce t=%0d got st=%b up=%b dn=%b any=%b exp st=%b up=%b dn=%b any=%b",
                 k, state, trans_up, trans_dn, any_event, m_state, m_up, m_dn, m_any);
      end
    end
    switch_input[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      dns += trans_dn[0];
    end
    vectors++;
    if (ups != 1 || dns != 1) begin
      errors++;
      $display("FAIL bounce_count got up=%0d dn=%0d exp 1 and 1", ups, dns);
    end
  endtask

  task automatic test_simultaneous();
    int anys = 0;
    switch_input = 4'b1010;
    for (int k = 1; k <= 8; k++) begin
      tick();
      anys += any_event;
      vectors++;
      if ({trans_up, trans_dn, any_event} !==
          {(k == 6) ? 4'b1010 : 4'b0000, (k == 6) ? 4'b0100 : 4'b0000, (k == 6)}) begin
        errors++;
        $display("FAIL simultaneous t=%0d got up=%b dn=%b any=%b", k, trans_up, trans_dn, any_event);
      end
    end
    vectors++;
    if (anys != 1 || state !== 4'b1010) begin
      errors++;
      $display("FAIL simultaneous_final got any_pulses=%0d st=%b exp 1 and 1010", anys, state);
    end
  endtask

  task automatic test_enable();
    ch_enable[2] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      switch_input[2] = k[0];
      tick();
      vectors++;
      if (state[2] !== 1'b0 || trans_up[2] !== 1'b0 || trans_dn[2] !== 1'b0) begin
        errors++;
        $display("FAIL enable_frozen t=%0d got st2=%b up2=%b dn2=%b exp 0", k, state[2], trans_up[2], trans_dn[2]);
      end
    end
    switch_input[2] = 1'b1;
    tick(); tick(); tick();
    ch_enable[2] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      vectors++;
      if (trans_up[2] !== (k == 4) || state[2] !== (k >= 4)) begin
        errors++;
        $display("FAIL enable_resume t=%0d got st2=%b up2=%b exp st2=%b up2=%b",
                 k, state[2], trans_up[2], (k >= 4), (k == 4));
      end
    end
  endtask

  task automatic test_reset_mid();
    switch_input[0] = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    #1;
    RST_N = 1'b0;
    #1;
    vectors++;
    if ({state, trans_up, trans_dn, any_event, long_press} !== {INIT, 4'b0, 4'b0, 1'b0, 4'b0}) begin
      errors++;
      $display("FAIL reset_async got st=%b up=%b dn=%b any=%b lp=%b exp st=%b rest 0",
               state, trans_up, trans_dn, any_event, long_press, INIT);
    end
    tick(); tick();
    RST_N = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      vectors++;
      if ({state, trans_up, trans_dn} !==
          {(k >= 6) ? 4'b1111 : INIT, (k == 6) ? 4'b1011 : 4'b0000, 4'b0000}) begin
        errors++;
        $display("FAIL reset_mid t=%0d got st=%b up=%b dn=%b", k, state, trans_up, trans_dn);
      end
    end
  endtask

  task automatic test_long_press();
    switch_input = 4'b0000;
    for (int k = 1; k <= 10; k++) tick();
    for (int rep = 0; rep < 2; rep++) begin
      switch_input[0] = 1'b1;
      for (int k = 1; k <= 30; k++) begin
        tick();
        vectors++;
        if (long_press !== ((LP_ON && k == 14) ? 4'b0001 : 4'b0000) || long_press !== m_lp) begin
          errors++;
          $display("FAIL long_press rep=%0d t=%0d got %b exp %b", rep, k, long_press,
                   (LP_ON && k == 14) ? 4'b0001 : 4'b0000);
        end
      end
      switch_input[0] = 1'b0;
      for (int k = 1; k <= 10; k++) tick();
    end
  endtask

  task automatic test_random();
    for (int k = 1; k <= 600; k++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(7) == 0) switch_input[i] = ~switch_input[i];
        if ($urandom_range(47) == 0) ch_enable[i] = ~ch_enable[i];
      end
      tick();
      vectors++;
      if ({state, trans_up, trans_dn, any_event, long_press} !== {m_state, m_up, m_dn, m_any, m_lp}) begin
        errors++;
        $display("FAIL random t=%0d got %b/%b/%b/%b/%b exp %b/%b/%b/%b/%b", k, state, trans_up,
                 trans_dn, any_event, long_press, m_state, m_up, m_dn, m_any, m_lp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_edge();
    test_bounce();
    test_simultaneous();
    test_enable();
    test_reset_mid();
    test_long_press();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
Parametrised N-channel successor to the single-switch debouncer. Each channel has:
- a 2-flop synchroniser;
- a programmable-length stability counter;
- a debounced state output;
- registered one-cycle up/down transition pulses.

It also adds a per-channel enable, an aggregate event flag and an optional long-press detector. It sits between raw board switches/buttons and the control logic.

Parameters:
- CHANNELS, 4: number of independent switch inputs.
- DEBOUNCE_CYCLES, 131072: consecutive cycles of stable mismatch required before the state toggles. Must be >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES): stability counter width per channel.
- INIT_STATE, {CHANNELS{1'b0}}: reset value of the synchroniser flops and of state.
- LONG_CYCLES, 8388608: cycles state must stay high to flag a long press. Used only with LONG_PRESS_EN.

Ports:
- CLK  in  1  system clock; all flops rising-edge.
- RST_N  in  1  asynchronous active-low reset.
- switch_input  in  CHANNELS  raw asynchronous switch levels.
- ch_enable  in  CHANNELS  per-channel enable; 1 = debounce active.
- state  out  CHANNELS  debounced level per channel.
- trans_up  out  CHANNELS  one-cycle pulse when state goes 0->1.
- trans_dn  out  CHANNELS  one-cycle pulse when state goes 1->0.
- any_event  out  1  registered OR of all trans_up/trans_dn bits, same cycle as those pulses.
- long_press  out  CHANNELS  one-cycle long-press pulse (optional feature).

Behaviour:
- Reset (RST_N low, async, takes effect immediately, including mid-count):
  - sync_0 = sync_1 = state = INIT_STATE;
  - all counters = 0;
  - trans_up = trans_dn = any_event = long_press = 0.
  - No transition pulse is generated on reset release.
- Synchroniser, per channel: sync_0 <= switch_input; sync_1 <= sync_0. The synchroniser runs regardless of ch_enable.
- mismatch[i] = (sync_1[i] != state[i]).
- Counter, per channel, in priority order:
  - if ch_enable[i] = 0 or mismatch[i] = 0: count <= 0;
  - else if count == DEBOUNCE_CYCLES-1: count <= 0, state[i] <= ~state[i];
  - else: count <= count + 1.
- Any single cycle without mismatch (bounce) restarts the count from 0.
- Latency: level change first sampled on edge 1 → state updates on edge DEBOUNCE_CYCLES+2, provided the input stays stable. Example: DEBOUNCE_CYCLES=4 → edge 6.
- Pulses:
  - trans_up[i] / trans_dn[i] are registered and assert for exactly one cycle, in the same cycle state[i] first shows its new value; otherwise 0.
  - any_event follows the same timing.
- Disable: with ch_enable[i] = 0, state[i] is frozen and no pulses are generated for that channel.
  - On re-enable with a standing mismatch, a fresh full DEBOUNCE_CYCLES count is required.
- Channels are fully independent. Simultaneous toggles on several channels all pulse in the same cycle; any_event is a single pulse.
- Counter never wraps: it is bounded at DEBOUNCE_CYCLES-1, then cleared.

Optional Feature:
LONG_PRESS_EN.
- Defined:
  - Each channel has a hold counter of $clog2(LONG_CYCLES) bits, cleared whenever state[i] = 0 or ch_enable[i] = 0; otherwise it increments.
  - When the hold counter reaches LONG_CYCLES-1, long_press[i] pulses for one cycle and the counter saturates. Only one pulse per press.
  - The counter re-arms only after state[i] returns to 0.
- Undefined: no hold counters; long_press is tied to 0; the port remains present.

Test Plan:
1. Clean edge: DEBOUNCE_CYCLES=4. Channel 0 input 0->1 before edge 1 → state[0]=1 after edge 6. trans_up[0]=1 and any_event=1 for that one cycle only. Other channels stay 0.
2. Bounce: DEBOUNCE_CYCLES=4. Input high 3 cycles, low 1, then high steady → no pulse until 4 full consecutive mismatch edges; exactly one trans_up. Release gives a single trans_dn.
3. Simultaneous: channels 1 and 3 rise on the same cycle, channel 2 falls from INIT_STATE=4'b0100 → trans_up=4'b1010 and trans_dn=4'b0100 in the same cycle; any_event is a single 1-cycle pulse.
4. Enable: ch_enable[2]=0 with the input toggled for 20 cycles → state[2] is unchanged and no pulses. Re-enable → toggles exactly 4 cycles after the enable edge (sync already settled).
5. Reset mid-count: assert RST_N low at count=2, async → state=INIT_STATE and outputs 0 immediately, without a clock edge. After release with the input still at the new level, a full 4+2-edge latency applies and there is no pulse at release.
6. LONG_PRESS_EN, LONG_CYCLES=8: hold a press → exactly one long_press pulse 8 cycles after state rises; no repeat while held. Release and re-press → a pulse again. Without the macro, long_press stays 0 throughout.
